// File: rtl/hdmi_mode_ctrl_if.sv
// Configuration request channel of the HDMI mode controller.
// The requester (master) drives a mode/pattern request with cfg_valid.
// The controller (slave) accepts it on a cycle where cfg_valid and cfg_ready are both high.
interface hdmi_mode_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_pattern;
  logic       cfg_auto;

  modport master (
    output cfg_valid,
    output cfg_mode,
    output cfg_pattern,
    output cfg_auto,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mode,
    input  cfg_pattern,
    input  cfg_auto,
    output cfg_ready
  );
endinterface

// File: rtl/hdmi_mode_ctrl.sv
// Configuration sequencer for the HDMI timing/pattern generator.
// Requests are accepted in RUN and applied on the next frame boundary.
// A mode change runs this sequence before video comes back:
//   - blank the output,
//   - pulse gen_rst,
//   - wait a number of settle frames.
// Optional patterns auto-advance every AUTO_FRAMES frames.
// Optional build macro: HDMI_MODE_CTRL_TIMEOUT_EN adds a watchdog in SETTLE and WAIT_FRAME.
// The watchdog forces a reset sequence if frame_start never arrives.
module hdmi_mode_ctrl #(
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned SETTLE_FRAMES  = 2,
  parameter int unsigned AUTO_FRAMES    = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic        clk,
  input  logic        rst,
  hdmi_mode_ctrl_if.slave cfg,
  input  logic        frame_start,
  output logic [11:0] h_active,
  output logic [11:0] h_fp,
  output logic [11:0] h_sync,
  output logic [11:0] h_bp,
  output logic [11:0] v_active,
  output logic [11:0] v_fp,
  output logic [11:0] v_sync,
  output logic [11:0] v_bp,
  output logic [3:0]  pattern_sel,
  output logic        gen_rst,
  output logic        video_en,
  output logic        busy,
  output logic [7:0]  frame_cnt,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    RESET_GEN  = 2'd0,
    SETTLE     = 2'd1,
    RUN        = 2'd2,
    WAIT_FRAME = 2'd3
  } state_t;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_fp;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [11:0] v_active;
    logic [11:0] v_fp;
    logic [11:0] v_sync;
    logic [11:0] v_bp;
  } timing_t;

  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_FRAMES - 1);
  localparam logic [15:0] AUTO_LAST   = 16'(AUTO_FRAMES - 1);

  // Mode 3 is not a real format; it shares the 1080p table, so it folds onto mode 0.
  // With that folding, 3 and 0 never look like a mode change.
  function automatic logic [1:0] resolve_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? 2'd0 : mode;
  endfunction

  function automatic timing_t timing_lookup(input logic [1:0] mode);
    timing_t t;
    case (mode)
      2'd1: t = '{h_active: 12'd1280, h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
                  v_active: 12'd720,  v_fp: 12'd5,   v_sync: 12'd5,  v_bp: 12'd20};
      2'd2: t = '{h_active: 12'd640,  h_fp: 12'd16,  h_sync: 12'd96, h_bp: 12'd48,
                  v_active: 12'd480,  v_fp: 12'd10,  v_sync: 12'd2,  v_bp: 12'd33};
      default:
            t = '{h_active: 12'd1920, h_fp: 12'd88,  h_sync: 12'd44, h_bp: 12'd148,
                  v_active: 12'd1080, v_fp: 12'd4,   v_sync: 12'd5,  v_bp: 12'd36};
    endcase
    return t;
  endfunction

  state_t      state;
  state_t      next_state;

  // Shared sequencing counter.
  // It counts cycles in RESET_GEN and frame pulses in SETTLE, and clears on every state change.
  logic [15:0] seq_cnt;
  logic [15:0] auto_cnt;

  // Shadow of the accepted request, held until the frame boundary that applies it.
  logic [1:0]  sh_mode;
  logic [3:0]  sh_pattern;
  logic        sh_auto;

  logic [1:0]  cur_mode;
  timing_t     timing;
  logic        auto_on;

  logic        gen_rst_d;
  logic        busy_d;
  logic        ready_d;
  logic        video_en_d;
  logic        err_d;

  logic        accept;
  logic        mode_same;
  logic        apply;
  logic        mode_chg;
  logic        auto_step;
  logic        wd_fire;

  assign accept    = (state == RUN) && cfg.cfg_valid && cfg.cfg_ready;
  assign mode_same = (resolve_mode(sh_mode) == cur_mode);
  // A frame pulse applies the request; a watchdog expiry forces the same action.
  assign apply     = (state == WAIT_FRAME) && (frame_start || wd_fire);
  // A watchdog expiry always restarts the generator, even with an unchanged mode.
  assign mode_chg  = apply && (!mode_same || wd_fire);
  // A request accepted on a frame pulse takes precedence over that pulse's auto step.
  assign auto_step = (state == RUN) && frame_start && auto_on && !accept;

`ifdef HDMI_MODE_CTRL_TIMEOUT_EN
  localparam logic [23:0] WD_LAST = TIMEOUT_CYCLES - 24'd1;

  logic [23:0] wd_cnt;
  logic        wd_active;

  assign wd_active = (state == WAIT_FRAME) || (state == SETTLE);
  assign wd_fire   = wd_active && !frame_start && (wd_cnt == WD_LAST);

  // Watchdog: counts idle cycles while waiting on the generator.
  // It restarts on every frame pulse, on expiry and outside the waiting states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (!wd_active || frame_start || wd_fire) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 24'd1;
    end
  end
`else
  // Watchdog compiled out.
  // The reduction keeps TIMEOUT_CYCLES referenced so both builds share one parameter list.
  assign wd_fire = &{1'b0, TIMEOUT_CYCLES};
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_GEN;
    end else begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values; blocking here would race other always_ff readers.
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned, which would infer a latch.
    next_state = state;
    unique case (state)
      RESET_GEN: begin
        if (seq_cnt == RST_LAST) next_state = SETTLE;
      end
      SETTLE: begin
        if (frame_start && (seq_cnt == SETTLE_LAST)) next_state = RUN;
        else if (wd_fire)                             next_state = RESET_GEN;
      end
      RUN: begin
        if (accept) next_state = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (apply) next_state = mode_chg ? RESET_GEN : RUN;
      end
    endcase
  end

  // Output decode.
  // Control outputs are computed from the next state and registered.
  // They therefore track the state register cycle for cycle.
  always_comb begin
    gen_rst_d  = (next_state == RESET_GEN);
    busy_d     = (next_state != RUN);
    ready_d    = (next_state == RUN);
    err_d      = wd_fire;
    video_en_d = video_en;
    if ((state == SETTLE) && (next_state == RUN)) begin
      video_en_d = 1'b1;
    end else if ((state != RESET_GEN) && (next_state == RESET_GEN)) begin
      video_en_d = 1'b0;
    end
  end

  // Control output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_rst       <= 1'b1;
      busy          <= 1'b1;
      cfg.cfg_ready <= 1'b0;
      video_en      <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      gen_rst       <= gen_rst_d;
      busy          <= busy_d;
      cfg.cfg_ready <= ready_d;
      video_en      <= video_en_d;
      err_timeout   <= err_d;
    end
  end

  // Sequencing counter for RESET_GEN cycles and SETTLE frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt <= '0;
    end else if (state != next_state) begin
      seq_cnt <= '0;
    end else if ((state == RESET_GEN) || ((state == SETTLE) && frame_start)) begin
      seq_cnt <= seq_cnt + 16'd1;
    end
  end

  // Shadow capture of an accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_mode    <= 2'd0;
      sh_pattern <= 4'd0;
      sh_auto    <= 1'b0;
    end else if (accept) begin
      sh_mode    <= cfg.cfg_mode;
      sh_pattern <= cfg.cfg_pattern;
      sh_auto    <= cfg.cfg_auto;
    end
  end

  // Apply the current mode and timing table on a frame boundary that changes the mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_mode <= 2'd0;
      timing   <= timing_lookup(2'd0);
    end else if (mode_chg) begin
      cur_mode <= resolve_mode(sh_mode);
      timing   <= timing_lookup(resolve_mode(sh_mode));
    end
  end

  // Pattern select and auto-cycle state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_sel <= 4'd0;
      auto_on     <= 1'b0;
      auto_cnt    <= '0;
    end else begin
      if (apply) begin
        pattern_sel <= sh_pattern;
        auto_on     <= sh_auto;
      end else if (auto_step && (auto_cnt == AUTO_LAST)) begin
        pattern_sel <= pattern_sel + 4'd1;
      end

      if (accept || (auto_step && (auto_cnt == AUTO_LAST))) begin
        auto_cnt <= '0;
      end else if (auto_step) begin
        auto_cnt <= auto_cnt + 16'd1;
      end
    end
  end

  // Frames shown since the last mode change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 8'd0;
    end else if (mode_chg) begin
      frame_cnt <= 8'd0;
    end else if (frame_start && video_en) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign h_active = timing.h_active;
  assign h_fp     = timing.h_fp;
  assign h_sync   = timing.h_sync;
  assign h_bp     = timing.h_bp;
  assign v_active = timing.v_active;
  assign v_fp     = timing.v_fp;
  assign v_sync   = timing.v_sync;
  assign v_bp     = timing.v_bp;

endmodule

// File: tb/tb_hdmi_mode_ctrl.sv
// Directed testbench for hdmi_mode_ctrl.
// Each scenario task drives stimulus and compares outputs against hand-computed values.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_hdmi_mode_ctrl;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic [11:0] h_active, h_fp, h_sync, h_bp;
  logic [11:0] v_active, v_fp, v_sync, v_bp;
  logic [3:0]  pattern_sel;
  logic        gen_rst, video_en, busy, err_timeout;
  logic [7:0]  frame_cnt;

  int passed = 0;
  int total  = 0;

  hdmi_mode_ctrl_if cfg_if ();

  hdmi_mode_ctrl #(
    .RST_CYCLES    (4),
    .SETTLE_FRAMES (2),
    .AUTO_FRAMES   (16),
    .TIMEOUT_CYCLES(24'd1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg        (cfg_if.slave),
    .frame_start(frame_start),
    .h_active   (h_active),
    .h_fp       (h_fp),
    .h_sync     (h_sync),
    .h_bp       (h_bp),
    .v_active   (v_active),
    .v_fp       (v_fp),
    .v_sync     (v_sync),
    .v_bp       (v_bp),
    .pattern_sel(pattern_sel),
    .gen_rst    (gen_rst),
    .video_en   (video_en),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic request(input logic [1:0] mode, input logic [3:0] pat, input logic au);
    cfg_if.cfg_valid   = 1'b1;
    cfg_if.cfg_mode    = mode;
    cfg_if.cfg_pattern = pat;
    cfg_if.cfg_auto    = au;
    tick(1);
    cfg_if.cfg_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    total++; if (gen_rst !== 1'b1)       $display("FAIL reset_gen_rst: got %b want 1", gen_rst); else passed++;
    total++; if (video_en !== 1'b0)      $display("FAIL reset_video_en: got %b want 0", video_en); else passed++;
    total++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL reset_cfg_ready: got %b want 0", cfg_if.cfg_ready); else passed++;
    total++; if (busy !== 1'b1)          $display("FAIL reset_busy: got %b want 1", busy); else passed++;
    total++; if (frame_cnt !== 8'd0)     $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); else passed++;
    total++; if (err_timeout !== 1'b0)   $display("FAIL reset_err_timeout: got %b want 0", err_timeout); else passed++;
    total++; if (pattern_sel !== 4'd0)   $display("FAIL reset_pattern_sel: got %0d want 0", pattern_sel); else passed++;
    total++; if (h_active !== 12'd1920)  $display("FAIL reset_h_active: got %0d want 1920", h_active); else passed++;
    rst = 1'b0;
    tick(3);
    total++; if (gen_rst !== 1'b1)       $display("FAIL reset_gen_rst_held: got %b want 1", gen_rst); else passed++;
    tick(1);
    total++; if (gen_rst !== 1'b0)       $display("FAIL reset_gen_rst_drop: got %b want 0", gen_rst); else passed++;
  endtask

  task automatic test_settle();
    tick(5);
    pulse_frame();
    total++; if (video_en !== 1'b0)      $display("FAIL settle_first_frame: got video_en %b want 0", video_en); else passed++;
    tick(5);
    pulse_frame();
    total++; if (video_en !== 1'b1)      $display("FAIL settle_video_en: got %b want 1", video_en); else passed++;
    total++; if (busy !== 1'b0)          $display("FAIL settle_busy: got %b want 0", busy); else passed++;
    total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL settle_cfg_ready: got %b want 1", cfg_if.cfg_ready); else passed++;
    total++; if (frame_cnt !== 8'd0)     $display("FAIL settle_frame_cnt: got %0d want 0", frame_cnt); else passed++;
    total++; if ({h_active, h_fp, h_sync, h_bp} !== {12'd1920, 12'd88, 12'd44, 12'd148})
      $display("FAIL settle_h_timing: got %0d/%0d/%0d/%0d want 1920/88/44/148", h_active, h_fp, h_sync, h_bp); else passed++;
    total++; if ({v_active, v_fp, v_sync, v_bp} !== {12'd1080, 12'd4, 12'd5, 12'd36})
      $display("FAIL settle_v_timing: got %0d/%0d/%0d/%0d want 1080/4/5/36", v_active, v_fp, v_sync, v_bp); else passed++;
  endtask

  task automatic test_mode_change();
    request(2'd1, 4'd5, 1'b0);
    total++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL mc_cfg_ready: got %b want 0", cfg_if.cfg_ready); else passed++;
    total++; if (busy !== 1'b1)          $display("FAIL mc_busy: got %b want 1", busy); else passed++;
    tick(5);
    total++; if (h_active !== 12'd1920)  $display("FAIL mc_early_h_active: got %0d want 1920", h_active); else passed++;
    total++; if (pattern_sel !== 4'd0)   $display("FAIL mc_early_pattern: got %0d want 0", pattern_sel); else passed++;
    total++; if (video_en !== 1'b1)      $display("FAIL mc_early_video_en: got %b want 1", video_en); else passed++;
    pulse_frame();
    total++; if ({h_active, h_fp, h_sync, h_bp} !== {12'd1280, 12'd110, 12'd40, 12'd220})
      $display("FAIL mc_h_timing: got %0d/%0d/%0d/%0d want 1280/110/40/220", h_active, h_fp, h_sync, h_bp); else passed++;
    total++; if ({v_active, v_fp, v_sync, v_bp} !== {12'd720, 12'd5, 12'd5, 12'd20})
      $display("FAIL mc_v_timing: got %0d/%0d/%0d/%0d want 720/5/5/20", v_active, v_fp, v_sync, v_bp); else passed++;
    total++; if (pattern_sel !== 4'd5)   $display("FAIL mc_pattern: got %0d want 5", pattern_sel); else passed++;
    total++; if (video_en !== 1'b0)      $display("FAIL mc_video_en_off: got %b want 0", video_en); else passed++;
    total++; if (gen_rst !== 1'b1)       $display("FAIL mc_gen_rst_on: got %b want 1", gen_rst); else passed++;
    tick(3);
    total++; if (gen_rst !== 1'b1)       $display("FAIL mc_gen_rst_held: got %b want 1", gen_rst); else passed++;
    tick(1);
    total++; if (gen_rst !== 1'b0)       $display("FAIL mc_gen_rst_drop: got %b want 0", gen_rst); else passed++;
    tick(3);
    pulse_frame();
    total++; if (video_en !== 1'b0)      $display("FAIL mc_settle_first: got video_en %b want 0", video_en); else passed++;
    tick(3);
    pulse_frame();
    total++; if (video_en !== 1'b1)      $display("FAIL mc_video_en_on: got %b want 1", video_en); else passed++;
    total++; if (frame_cnt !== 8'd0)     $display("FAIL mc_frame_cnt: got %0d want 0", frame_cnt); else passed++;
  endtask

  task automatic test_same_mode();
    request(2'd1, 4'd9, 1'b0);
    tick(3);
    total++; if (gen_rst !== 1'b0 || video_en !== 1'b1)
      $display("FAIL same_wait: got gen_rst %b video_en %b want 0 1", gen_rst, video_en); else passed++;
    pulse_frame();
    total++; if (pattern_sel !== 4'd9)   $display("FAIL same_pattern: got %0d want 9", pattern_sel); else passed++;
    total++; if (gen_rst !== 1'b0 || video_en !== 1'b1)
      $display("FAIL same_apply: got gen_rst %b video_en %b want 0 1", gen_rst, video_en); else passed++;
    total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL same_cfg_ready: got %b want 1", cfg_if.cfg_ready); else passed++;
    total++; if (frame_cnt !== 8'd1)     $display("FAIL same_frame_cnt: got %0d want 1", frame_cnt); else passed++;
    total++; if (h_active !== 12'd1280)  $display("FAIL same_h_active: got %0d want 1280", h_active); else passed++;
  endtask

  task automatic test_auto();
    request(2'd1, 4'd14, 1'b1);
    tick(2);
    pulse_frame();
    total++; if (pattern_sel !== 4'd14)  $display("FAIL auto_apply: got %0d want 14", pattern_sel); else passed++;
    for (int i = 1; i <= 32; i++) begin
      tick(2);
      pulse_frame();
      if (i == 15 || i == 16 || i == 31 || i == 32) begin
        logic [3:0] want;
        want = (i == 15) ? 4'd14 : (i == 32) ? 4'd0 : 4'd15;
        total++; if (pattern_sel !== want)
          $display("FAIL auto_frame%0d: got %0d want %0d", i, pattern_sel, want); else passed++;
      end
    end
    total++; if (frame_cnt !== 8'd34)    $display("FAIL auto_frame_cnt: got %0d want 34", frame_cnt); else passed++;
    request(2'd1, 4'd2, 1'b0);
    tick(1);
    pulse_frame();
    total++; if (pattern_sel !== 4'd2)   $display("FAIL auto_off: got %0d want 2", pattern_sel); else passed++;
  endtask

  task automatic test_coincident();
    cfg_if.cfg_valid   = 1'b1;
    cfg_if.cfg_mode    = 2'd1;
    cfg_if.cfg_pattern = 4'd3;
    cfg_if.cfg_auto    = 1'b0;
    frame_start        = 1'b1;
    tick(1);
    cfg_if.cfg_valid   = 1'b0;
    frame_start        = 1'b0;
    total++; if (pattern_sel !== 4'd2)   $display("FAIL coin_unchanged: got %0d want 2", pattern_sel); else passed++;
    total++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL coin_cfg_ready: got %b want 0", cfg_if.cfg_ready); else passed++;
    total++; if (frame_cnt !== 8'd36)    $display("FAIL coin_frame_cnt: got %0d want 36", frame_cnt); else passed++;
    tick(3);
    pulse_frame();
    total++; if (pattern_sel !== 4'd3)   $display("FAIL coin_apply: got %0d want 3", pattern_sel); else passed++;
    total++; if (frame_cnt !== 8'd37)    $display("FAIL coin_frame_cnt2: got %0d want 37", frame_cnt); else passed++;
  endtask

  task automatic test_rst_mid_settle();
    request(2'd2, 4'd4, 1'b0);
    tick(2);
    pulse_frame();
    total++; if ({h_active, v_sync} !== {12'd640, 12'd2})
      $display("FAIL mid_480p: got h_active %0d v_sync %0d want 640 2", h_active, v_sync); else passed++;
    tick(4);
    total++; if (gen_rst !== 1'b0)       $display("FAIL mid_settle_entry: got gen_rst %b want 0", gen_rst); else passed++;
    tick(2);
    pulse_frame();
    #2;
    rst = 1'b1;
    #1;
    total++; if (gen_rst !== 1'b1 || busy !== 1'b1 || video_en !== 1'b0 || cfg_if.cfg_ready !== 1'b0)
      $display("FAIL mid_rst_ctrl: got gen_rst %b busy %b video_en %b ready %b want 1 1 0 0",
               gen_rst, busy, video_en, cfg_if.cfg_ready); else passed++;
    total++; if ({h_active, v_bp} !== {12'd1920, 12'd36})
      $display("FAIL mid_rst_timing: got h_active %0d v_bp %0d want 1920 36", h_active, v_bp); else passed++;
    total++; if (pattern_sel !== 4'd0 || frame_cnt !== 8'd0 || err_timeout !== 1'b0)
      $display("FAIL mid_rst_misc: got pattern %0d frame_cnt %0d err %b want 0 0 0",
               pattern_sel, frame_cnt, err_timeout); else passed++;
    tick(1);
    rst = 1'b0;
    tick(4);
    tick(2);
    pulse_frame();
    tick(2);
    pulse_frame();
    total++; if (video_en !== 1'b1)      $display("FAIL mid_recover: got video_en %b want 1", video_en); else passed++;
    request(2'd3, 4'd7, 1'b0);
    tick(2);
    pulse_frame();
    total++; if (pattern_sel !== 4'd7)   $display("FAIL mode3_pattern: got %0d want 7", pattern_sel); else passed++;
    total++; if (gen_rst !== 1'b0 || video_en !== 1'b1 || busy !== 1'b0)
      $display("FAIL mode3_no_reset: got gen_rst %b video_en %b busy %b want 0 1 0", gen_rst, video_en, busy); else passed++;
    total++; if (h_active !== 12'd1920)  $display("FAIL mode3_h_active: got %0d want 1920", h_active); else passed++;
  endtask

`ifdef HDMI_MODE_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int fired_at;
    fired_at = 0;
    request(2'd2, 4'd0, 1'b0);
    for (int i = 1; i <= 1100; i++) begin
      tick(1);
      if (err_timeout === 1'b1) begin
        fired_at = i;
        break;
      end
    end
    total++; if (fired_at != 1000)       $display("FAIL to_cycle: got %0d want 1000", fired_at); else passed++;
    total++; if (h_active !== 12'd640)   $display("FAIL to_h_active: got %0d want 640", h_active); else passed++;
    total++; if (gen_rst !== 1'b1 || video_en !== 1'b0)
      $display("FAIL to_ctrl: got gen_rst %b video_en %b want 1 0", gen_rst, video_en); else passed++;
    tick(1);
    total++; if (err_timeout !== 1'b0)   $display("FAIL to_pulse_width: got %b want 0", err_timeout); else passed++;
  endtask
`else
  task automatic test_timeout();
    request(2'd2, 4'd0, 1'b0);
    tick(200);
    total++; if (err_timeout !== 1'b0)   $display("FAIL nto_err: got %b want 0", err_timeout); else passed++;
    total++; if (h_active !== 12'd1920 || busy !== 1'b1)
      $display("FAIL nto_waiting: got h_active %0d busy %b want 1920 1", h_active, busy); else passed++;
    pulse_frame();
    total++; if (h_active !== 12'd640 || gen_rst !== 1'b1)
      $display("FAIL nto_apply: got h_active %0d gen_rst %b want 640 1", h_active, gen_rst); else passed++;
  endtask
`endif

  initial begin
    rst                = 1'b1;
    frame_start        = 1'b0;
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_mode    = 2'd0;
    cfg_if.cfg_pattern = 4'd0;
    cfg_if.cfg_auto    = 1'b0;
    test_reset();
    test_settle();
    test_mode_change();
    test_same_mode();
    test_auto();
    test_coincident();
    test_rst_mid_settle();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hdmi_mode_ctrl.md
Name: hdmi_mode_ctrl

Overview:
Configuration sequencer for the HDMI timing/pattern generator. Accepts mode and pattern requests over a valid/ready handshake and drives the generator's timing parameters and pattern select. Applies every change on a frame boundary. Mode changes run a safe sequence: blank output, pulse the generator reset, then wait a number of settle frames before re-enabling video. Optionally auto-cycles patterns every N frames.

Parameters:
RST_CYCLES, 4, cycles gen_rst is held high per reset sequence (min 1)
SETTLE_FRAMES, 2, frame_start pulses counted after gen_rst before video_en rises (min 1)
AUTO_FRAMES, 16, frames per pattern step in auto mode (min 1)
TIMEOUT_CYCLES, 24'd5000000, watchdog limit (only used with the optional feature)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  config request valid
cfg_ready  out  1  config request accepted when valid&ready
cfg_mode  in  2  0=1080p60, 1=720p60, 2=480p60, 3=treated as 0
cfg_pattern  in  4  requested pattern index
cfg_auto  in  1  1=auto-cycle patterns
frame_start  in  1  one-cycle pulse from generator at vsync leading edge
h_active, h_fp, h_sync, h_bp  out  12 each  horizontal timing to generator
v_active, v_fp, v_sync, v_bp  out  12 each  vertical timing to generator
pattern_sel  out  4  pattern select to image generator
gen_rst  out  1  synchronous reset to timing generator
video_en  out  1  gates de/rgb downstream
busy  out  1  1 whenever state != RUN
frame_cnt  out  8  frames since last mode change
err_timeout  out  1  watchdog pulse

Behaviour:
- Timing tables (active/fp/sync/bp):
  - 1080p: H 1920/88/44/148, V 1080/4/5/36.
  - 720p: H 1280/110/40/220, V 720/5/5/20.
  - 480p: H 640/16/96/48, V 480/10/2/33.
- Reset values:
  - state=RESET_GEN, timing outputs=1080p, pattern_sel=0, auto=0.
  - gen_rst=1, video_en=0, cfg_ready=0, busy=1, frame_cnt=0, err_timeout=0.
  - Shadow and counters cleared.
- States:
  - RESET_GEN: gen_rst=1. Count RST_CYCLES cycles, then go to SETTLE with gen_rst=0 and the counter cleared. frame_start is ignored in this state.
  - SETTLE: count frame_start pulses. On the SETTLE_FRAMES-th pulse, video_en<=1 and go to RUN.
  - RUN: cfg_ready=1. On acceptance, latch cfg_* into shadow, clear the auto counter, set cfg_ready=0 the next cycle, and go to WAIT_FRAME.
  - WAIT_FRAME: on frame_start:
    - If shadow mode equals the current mode: apply pattern_sel and auto, then return to RUN. video_en is unchanged.
    - If the mode differs: video_en<=0, timing outputs<=new table, pattern_sel/auto applied, frame_cnt<=0, then go to RESET_GEN.
- Mode 3 vs mode 0 compare as equal: both resolve to the same table, so no reset sequence.
- cfg_valid and frame_start in the same RUN cycle: the request is accepted, but that pulse does not apply it. It applies at the next frame_start. The pulse still counts for frame_cnt.
- Auto mode (RUN only): count frame_start pulses. On the AUTO_FRAMES-th pulse, pattern_sel<=pattern_sel+1 (15 wraps to 0) and the counter clears.
- frame_cnt increments on frame_start while video_en=1, wrapping 255 to 0.
- All outputs are registered. A timing-table change is visible one cycle after the applying frame_start.
- rst asserted mid-sequence returns every register to its reset value immediately. Any accepted but unapplied request is discarded.

Optional Feature:
HDMI_MODE_CTRL_TIMEOUT_EN:
- Defined: a cycle counter runs in WAIT_FRAME and SETTLE and clears on each frame_start. On reaching TIMEOUT_CYCLES:
  - err_timeout pulses for 1 cycle.
  - In WAIT_FRAME, any pending mode change is applied immediately, as if frame_start had occurred.
  - Next state is RESET_GEN (gen_rst reasserted), with video_en=0.
- Undefined: no counter; both states wait indefinitely; err_timeout is tied 0. The port exists in both builds.

Test Plan:
- Release rst, issue frame_start every 100 cycles → gen_rst high for exactly 4 cycles after release; video_en rises 1 cycle after the 2nd frame_start; timing outputs read 1920/88/44/148/1080/4/5/36.
- In RUN, request mode=1 pattern=5 → cfg_ready low next cycle; no output change until frame_start. Then h_active=1280, v_bp=20, pattern_sel=5, video_en=0, gen_rst high 4 cycles, video_en=1 after 2 more frames, frame_cnt=0 at re-enable.
- Request same mode with pattern=9 → pattern_sel=9 one cycle after the next frame_start; gen_rst stays 0 and video_en stays 1 throughout.
- cfg_auto=1 with pattern=14, AUTO_FRAMES=16 → pattern_sel=15 after the 16th frame and 0 after the 32nd.
- cfg_valid coincident with frame_start (pattern=3) → pattern_sel unchanged on that pulse, =3 after the next; assert rst mid-SETTLE → all outputs back to reset values.
- With HDMI_MODE_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=1000: request mode=2, then no frame_start → err_timeout pulses at cycle 1000, h_active=640, gen_rst asserted.
